iq_stream_packer: RTL and testbench

Parametrised successor to the fixed 8-word output streaming path of the readout top level. It captures N_CH demodulated I/Q pairs from the decimation filters on a decimated-rate strobe and applies a per-frame gain shift with signed saturation. It then serialises only the channels enabled in a runtime mask into a byte stream framed with a sync byte, a flags byte and an XOR checksum, using a valid/ready handshake. The byte stream feeds the transmit FIFO and UART.

---
 rtl/iq_stream_packer.sv | 201 ++++++++++++++++++++
 tb/tb_iq_stream_packer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_stream_packer.sv
// I/Q capture, gain shift with saturation, and framed byte serialiser.
// Ports: i_clk/i_rst_n, i_en/i_strobe capture, i_i/i_q samples, i_ch_mask,
//   i_shift, i_trig; o_data/o_valid/i_ready stream; o_busy, o_overrun, o_seq.
module iq_stream_packer #(
   parameter int N_CH = 4,
   parameter int IN_WIDTH = 17,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT_WIDTH = 3,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_en,
   input  logic                     i_strobe,
   input  logic [N_CH*IN_WIDTH-1:0] i_i,
   input  logic [N_CH*IN_WIDTH-1:0] i_q,
   input  logic [N_CH-1:0]          i_ch_mask,
   input  logic [SHIFT_WIDTH-1:0]   i_shift,
   input  logic                     i_trig,
   output logic [7:0]               o_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic                     o_busy,
   output logic                     o_overrun,
   output logic [5:0]               o_seq
);
   localparam int BPS = OUT_WIDTH / 8;
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int BW = (BPS > 1) ? $clog2(BPS) : 1;
   localparam int XW = IN_WIDTH - OUT_WIDTH + 1;

   localparam logic signed [IN_WIDTH-1:0] SMAX =
      {{XW{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [IN_WIDTH-1:0] SMIN =
      {{XW{1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SYNC  = 3'd2;
   localparam logic [2:0] S_FLAGS = 3'd3;
   localparam logic [2:0] S_MASK  = 3'd4;
   localparam logic [2:0] S_PAY   = 3'd5;
   localparam logic [2:0] S_CKSUM = 3'd6;

   logic [2:0]             state;
   logic [IN_WIDTH-1:0]    raw_i [N_CH];
   logic [IN_WIDTH-1:0]    raw_q [N_CH];
   logic [OUT_WIDTH-1:0]   samp_i [N_CH];
   logic [OUT_WIDTH-1:0]   samp_q [N_CH];
   logic [N_CH-1:0]        mask_q;
   logic [SHIFT_WIDTH-1:0] shift_q;
   logic                   trig_q;
   logic                   ovr_q;
   logic                   ovr_pend;
   logic [CW-1:0]          ch;
   logic                   iq;
   logic [BW-1:0]          bidx;
   logic [7:0]             cks;
   logic [CW-1:0]          first_ch;
   logic [CW-1:0]          nxt_ch;
   logic                   nxt_ok;
   logic [OUT_WIDTH-1:0]   cur;
   logic [7:0]             pay_byte;
   logic                   xfer;
   logic                   capture;
   logic                   drop;

   function automatic logic [OUT_WIDTH-1:0] sat(
      input logic [IN_WIDTH-1:0]    x,
      input logic [SHIFT_WIDTH-1:0] sh
   );
      logic signed [IN_WIDTH-1:0] s;
      s = $signed(x) >>> sh;
      if (s > SMAX) return SMAX[OUT_WIDTH-1:0];
      if (s < SMIN) return SMIN[OUT_WIDTH-1:0];
      return s[OUT_WIDTH-1:0];
   endfunction

   assign o_valid = (state != S_IDLE) && (state != S_LOAD);
   assign o_busy  = (state != S_IDLE);
   assign xfer    = o_valid && i_ready;
   // Back-to-back capture is allowed on the checksum handshake edge.
   assign capture = i_en && i_strobe &&
      ((state == S_IDLE) || ((state == S_CKSUM) && xfer));
   assign drop    = i_en && i_strobe && !capture;

   // Lowest enabled channel, and lowest enabled channel above ch.
   always_comb begin
      first_ch = '0;
      nxt_ch   = '0;
      nxt_ok   = 1'b0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         if (mask_q[c]) first_ch = CW'(c);
         if (mask_q[c] && (c > int'(ch))) begin
            nxt_ch = CW'(c);
            nxt_ok = 1'b1;
         end
      end
   end

   always_comb begin
      cur      = iq ? samp_q[ch] : samp_i[ch];
      pay_byte = '0;
      for (int b = 0; b < BPS; b++)
         if (int'(bidx) == b) pay_byte = cur[(BPS-1-b)*8 +: 8];
      case (state)
         S_SYNC:  o_data = SYNC_BYTE;
         S_FLAGS: o_data = {trig_q, ovr_q, o_seq};
         S_MASK:  o_data = 8'(mask_q);
         S_PAY:   o_data = pay_byte;
         S_CKSUM: o_data = cks;
         default: o_data = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_IDLE;
         mask_q    <= '0;
         shift_q   <= '0;
         trig_q    <= 1'b0;
         ovr_q     <= 1'b0;
         ovr_pend  <= 1'b0;
         o_overrun <= 1'b0;
         o_seq     <= '0;
         ch        <= '0;
         iq        <= 1'b0;
         bidx      <= '0;
         cks       <= '0;
         for (int c = 0; c < N_CH; c++) begin
            raw_i[c]  <= '0;
            raw_q[c]  <= '0;
            samp_i[c] <= '0;
            samp_q[c] <= '0;
         end
      end else begin
         o_overrun <= drop;
         if (drop) ovr_pend <= 1'b1;
         case (state)
            S_LOAD: begin
               for (int c = 0; c < N_CH; c++) begin
                  samp_i[c] <= sat(raw_i[c], shift_q);
                  samp_q[c] <= sat(raw_q[c], shift_q);
               end
               state <= S_SYNC;
            end
            S_SYNC:
               if (xfer) state <= S_FLAGS;
            S_FLAGS:
               if (xfer) begin
                  cks   <= cks ^ o_data;
                  state <= S_MASK;
               end
            S_MASK:
               if (xfer) begin
                  cks  <= cks ^ o_data;
                  ch   <= first_ch;
                  iq   <= 1'b0;
                  bidx <= '0;
                  state <= (mask_q == '0) ? S_CKSUM : S_PAY;
               end
            S_PAY:
               if (xfer) begin
                  cks <= cks ^ o_data;
                  if (bidx == BW'(BPS - 1)) begin
                     bidx <= '0;
                     if (!iq) begin
                        iq <= 1'b1;
                     end else begin
                        iq <= 1'b0;
                        if (nxt_ok) ch <= nxt_ch;
                        else state <= S_CKSUM;
                     end
                  end else begin
                     bidx <= bidx + 1'b1;
                  end
               end
            S_CKSUM:
               if (xfer) begin
                  o_seq <= o_seq + 6'd1;
                  state <= S_IDLE;
               end
            default:
               state <= S_IDLE;
         endcase
         if (capture) begin
            for (int c = 0; c < N_CH; c++) begin
               raw_i[c] <= i_i[c*IN_WIDTH +: IN_WIDTH];
               raw_q[c] <= i_q[c*IN_WIDTH +: IN_WIDTH];
            end
            mask_q   <= i_ch_mask;
            shift_q  <= i_shift;
            trig_q   <= i_trig;
            ovr_q    <= ovr_pend;
            ovr_pend <= 1'b0;
            cks      <= '0;
            state    <= S_LOAD;
         end
      end
   end
endmodule

// File: tb/tb_iq_stream_packer.sv
// Scoreboard bench for iq_stream_packer: expected bytes queued by stimulus,
// popped and compared by a negedge monitor on every handshake.
module tb_iq_stream_packer;
   localparam int N = 4;
   localparam int IW = 17;

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic            i_en = 1'b0;
   logic            i_strobe = 1'b0;
   logic [N*IW-1:0] i_i = '0;
   logic [N*IW-1:0] i_q = '0;
   logic [N-1:0]    i_ch_mask = '0;
   logic [2:0]      i_shift = '0;
   logic            i_trig = 1'b0;
   logic            i_ready = 1'b1;
   logic [7:0]      o_data;
   logic            o_valid;
   logic            o_busy;
   logic            o_overrun;
   logic [5:0]      o_seq;

   iq_stream_packer dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
      .i_strobe(i_strobe), .i_i(i_i), .i_q(i_q),
      .i_ch_mask(i_ch_mask), .i_shift(i_shift), .i_trig(i_trig),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_busy(o_busy), .o_overrun(o_overrun), .o_seq(o_seq)
   );

   always #5 i_clk = ~i_clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exq[$];
   logic [7:0]  pl[$];
   logic [16:0] vi[N];
   logic [16:0] vq[N];
   logic [5:0]  exp_seq = '0;
   logic        hold_chk = 1'b0;
   logic [7:0]  hold_b = '0;

   always @(negedge i_clk) begin
      logic [7:0] b;
      if (!i_rst_n) begin
         hold_chk = 1'b0;
      end else begin
         if (hold_chk) begin
            checks++;
            if (!o_valid || o_data !== hold_b) begin
               errors++;
               $display("FAIL hold: valid=%0b data=%02h need %02h",
                        o_valid, o_data, hold_b);
            end
         end
         hold_chk = o_valid && !i_ready;
         hold_b = o_data;
         if (o_valid && i_ready) begin
            checks++;
            if (exq.size() == 0) begin
               errors++;
               $display("FAIL extra_byte: got %02h, none expected", o_data);
            end else begin
               b = exq.pop_front();
               if (o_data !== b) begin
                  errors++;
                  $display("FAIL byte: got %02h expected %02h", o_data, b);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_pl(input logic trig, input logic ovr,
                          input logic [3:0] mask);
      logic [7:0] f;
      logic [7:0] ck;
      f = {trig, ovr, exp_seq};
      ck = f ^ {4'h0, mask};
      exq.push_back(8'hA5);
      exq.push_back(f);
      exq.push_back({4'h0, mask});
      foreach (pl[k]) begin
         exq.push_back(pl[k]);
         ck ^= pl[k];
      end
      exq.push_back(ck);
      exp_seq = exp_seq + 6'd1;
   endtask

   // Inputs are chosen in range with shift 0, so payload = low 16 bits.
   task automatic push_frame(input logic trig, input logic ovr,
                             input logic [3:0] mask);
      pl.delete();
      for (int c = 0; c < N; c++)
         if (mask[c]) begin
            pl.push_back(vi[c][15:8]);
            pl.push_back(vi[c][7:0]);
            pl.push_back(vq[c][15:8]);
            pl.push_back(vq[c][7:0]);
         end
      push_pl(trig, ovr, mask);
   endtask

   task automatic send(input logic [3:0] mask, input logic [2:0] sh,
                       input logic trig, input logic en);
      for (int c = 0; c < N; c++) begin
         i_i[c*IW +: IW] = vi[c];
         i_q[c*IW +: IW] = vq[c];
      end
      i_ch_mask = mask;
      i_shift = sh;
      i_trig = trig;
      i_en = en;
      i_strobe = 1'b1;
      @(posedge i_clk);
      #1;
      i_strobe = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd);
      int n;
      n = 0;
      while ((exq.size() != 0 || o_busy) && n < 1000) begin
         if (rnd) i_ready = 1'($urandom_range(0, 1));
         @(posedge i_clk);
         #1;
         n++;
      end
      i_ready = 1'b1;
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("FAIL timeout: busy=%0b left=%0d need idle", o_busy,
                  exq.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t exceeded", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0]  basic[8];
      logic [16:0] sv[4];
      logic [2:0]  ss[4];
      logic [15:0] se[4];
      basic = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'hFF, 8'hFB, 8'h27};
      sv = '{17'h0FFFF, 17'h10000, 17'h10000, 17'h0FFFF};
      ss = '{3'd0, 3'd0, 3'd2, 3'd1};
      se = '{16'h7FFF, 16'h8000, 16'hC000, 16'h7FFF};
      for (int c = 0; c < N; c++) begin
         vi[c] = '0;
         vq[c] = '0;
      end

      #12;
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ovr", o_overrun, 0);
      chk("rst_seq", o_seq, 0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // basic frame, latency
      vi[0] = 17'h00123;
      vq[0] = 17'h1FFFB;
      foreach (basic[k]) exq.push_back(basic[k]);
      exp_seq = exp_seq + 6'd1;
      send(4'b0001, 3'd0, 1'b0, 1'b1);
      chk("lat_load_valid", o_valid, 0);
      @(posedge i_clk);
      #1;
      chk("lat_sync_valid", o_valid, 1);
      chk("lat_sync_data", o_data, 8'hA5);
      wait_idle(0);
      chk("seq_basic", o_seq, 1);

      // shift and saturation
      vq[0] = '0;
      for (int k = 0; k < 4; k++) begin
         vi[0] = sv[k];
         pl.delete();
         pl.push_back(se[k][15:8]);
         pl.push_back(se[k][7:0]);
         pl.push_back(8'h00);
         pl.push_back(8'h00);
         push_pl(1'b0, 1'b0, 4'b0001);
         send(4'b0001, ss[k], 1'b0, 1'b1);
         wait_idle(0);
      end

      // i_en low: strobe ignored, no overrun
      send(4'b0001, 3'd0, 1'b0, 1'b0);
      chk("en_low_ovr", o_overrun, 0);
      @(posedge i_clk);
      #1;
      chk("en_low_busy", o_busy, 0);
      i_en = 1'b1;

      // full mask reference, then with backpressure
      vi = '{17'h01234, 17'h05678, 17'h00ABC, 17'h1FF00};
      vq = '{17'h07FFF, 17'h18000, 17'h00001, 17'h1FFFF};
      push_frame(1'b0, 1'b0, 4'b1111);
      send(4'b1111, 3'd0, 1'b0, 1'b1);
      wait_idle(0);
      push_frame(1'b0, 1'b0, 4'b1111);
      send(4'b1111, 3'd0, 1'b0, 1'b1);
      wait_idle(1);
      chk("seq_bp", o_seq, exp_seq);

      // back-to-back on the checksum handshake
      vi[0] = 17'h00321;
      vq[0] = 17'h00ABC;
      push_frame(1'b0, 1'b0, 4'b0001);
      push_frame(1'b0, 1'b0, 4'b0001);
      send(4'b0001, 3'd0, 1'b0, 1'b1);
      repeat (8) begin
         @(posedge i_clk);
         #1;
      end
      chk("b2b_cks_valid", o_valid, 1);
      send(4'b0001, 3'd0, 1'b0, 1'b1);
      chk("b2b_no_ovr", o_overrun, 0);
      chk("b2b_load", o_valid, 0);
      @(posedge i_clk);
      #1;
      chk("b2b_sync_valid", o_valid, 1);
      chk("b2b_sync_data", o_data, 8'hA5);
      wait_idle(0);
      chk("seq_b2b", o_seq, exp_seq);

      // empty mask with trig, across seq wrap
      for (int k = 0; k < 64; k++) begin
         pl.delete();
         push_pl(1'b1, 1'b0, 4'b0000);
         send(4'b0000, 3'd0, 1'b1, 1'b1);
         wait_idle(0);
         if (k == 0 || exp_seq == 6'd0 || k == 63)
            chk("seq_wrap", o_seq, exp_seq);
      end

      // reset during payload
      vi = '{17'h01234, 17'h05678, 17'h00ABC, 17'h1FF00};
      push_frame(1'b0, 1'b0, 4'b1111);
      send(4'b1111, 3'd0, 1'b0, 1'b1);
      repeat (5) begin
         @(posedge i_clk);
         #1;
      end
      chk("pre_rst_valid", o_valid, 1);
      i_rst_n = 1'b0;
      #1;
      chk("arst_valid", o_valid, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_seq", o_seq, 0);
      chk("arst_data", o_data, 0);
      exq.delete();
      exp_seq = '0;
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // overrun during payload
      push_frame(1'b0, 1'b0, 4'b1111);
      send(4'b1111, 3'd0, 1'b0, 1'b1);
      repeat (4) begin
         @(posedge i_clk);
         #1;
      end
      chk("ovr_pre", o_overrun, 0);
      send(4'b1111, 3'd0, 1'b0, 1'b1);
      chk("ovr_pulse", o_overrun, 1);
      @(posedge i_clk);
      #1;
      chk("ovr_end", o_overrun, 0);
      wait_idle(0);
      chk("seq_ovr", o_seq, 1);
      pl.delete();
      exq.push_back(8'hA5);
      exq.push_back(8'h41);
      exq.push_back(8'h00);
      exq.push_back(8'h41);
      exp_seq = exp_seq + 6'd1;
      send(4'b0000, 3'd0, 1'b0, 1'b1);
      wait_idle(0);
      push_frame(1'b0, 1'b0, 4'b0010);
      send(4'b0010, 3'd0, 1'b0, 1'b1);
      wait_idle(0);
      chk("seq_end", o_seq, 3);
      chk("queue_empty", exq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
